edge_meas: RTL and testbench
============================

EDGE_MEAS -- requirements
Module: edge_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the measurement counters (legal range 4..32).
REQ-002 SHALL have port clk, input, 1 bit: clock, with all state updating on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port rise, input, 1 bit: single-cycle rising-edge strobe from the upstream edge detector.
REQ-005 SHALL have port down, input, 1 bit: single-cycle falling-edge strobe from the upstream edge detector.
REQ-006 SHALL have port meas_ready, input, 1 bit: the consumer accepts the measurement.
REQ-007 SHALL have port meas_valid, output, 1 bit: a measurement is available.
REQ-008 SHALL have port high_cnt, output, CNT_W bits: cycles from a rise strobe to the following down strobe.
REQ-009 SHALL have port period_cnt, output, CNT_W bits: cycles between two consecutive rise strobes.
REQ-010 SHALL have port ovf, output, 1 bit: the presented measurement saturated.
REQ-011 SHALL have port drop, output, 1 bit: one-cycle pulse, a completed measurement was lost.

Function
REQ-012 SHALL use an FSM with states IDLE, HIGH and LOW, and enter IDLE on reset.
REQ-013 SHALL, when rise is seen in IDLE, load the period counter to 1 and go to HIGH.
REQ-014 SHALL, in HIGH or LOW on any cycle without rise, increment the period counter, saturating at 2^CNT_W-1 and setting an internal ovf flag on saturation.
REQ-015 SHALL, when down is seen in HIGH, latch the current period counter value as the high width and go to LOW.
REQ-016 SHALL, when rise is seen in LOW, complete a measurement (period = current counter, high = latched width, ovf = flag), reload the counter to 1, clear the flag and go to HIGH.
REQ-017 SHALL, when rise is seen in HIGH (down missing), discard the partial measurement, reload the counter to 1, clear the flag and stay in HIGH, without asserting drop.
REQ-018 SHALL ignore down in IDLE and in LOW.
REQ-019 SHALL treat rise and down asserted in the same cycle as no event, with counting continuing.
REQ-020 SHALL update its outputs through a one-entry register: a completed measurement loads when meas_valid=0 or meas_ready=1, sets meas_valid, and appears the cycle after completion.
REQ-021 SHALL hold high_cnt, period_cnt and ovf stable while meas_valid=1 and meas_ready=0.
REQ-022 SHALL clear meas_valid after a cycle with meas_valid=1 and meas_ready=1, unless a new measurement loads in that same cycle.
REQ-023 SHALL, when a measurement completes while meas_valid=1 and meas_ready=0, discard the new measurement, keep the held one, and pulse drop for one cycle.
REQ-024 SHALL ignore meas_ready while meas_valid=0.

Reset
REQ-025 SHALL, while rst_n=1, asynchronously force state=IDLE, all counters=0, flags=0, meas_valid=0, high_cnt=0, period_cnt=0, ovf=0 and drop=0.
REQ-026 SHALL, when reset is asserted mid-measurement, abandon that measurement and lose any held output, then wait for a fresh rise after release.

Structure
REQ-027 SHALL define the state enum (IDLE/HIGH/LOW) and the CNT_W default constant in a shared package, edge_meas_pkg.
REQ-028 SHALL implement the period counter as one sub-module, sat_counter (load-1, increment, saturate flag), parameterised by CNT_W.
REQ-029 SHALL be implementable in roughly 150-250 lines of RTL in total.

Verification
REQ-030 SHALL be checked by: rise@0, down@3, rise@10, meas_ready=1 -> meas_valid at cycle 11 with high_cnt=3, period_cnt=10, ovf=0.
REQ-031 SHALL be checked by: CNT_W=4, rise@0, down@5, rise@40 -> high_cnt=5, period_cnt=15, ovf=1.
REQ-032 SHALL be checked by: meas_ready=0, two complete periods -> first measurement held stable, drop pulses once at the second completion, meas_valid stays 1.
REQ-033 SHALL be checked by: rise@0, rise@4 (no down), down@6, rise@12 -> a single measurement with high_cnt=2, period_cnt=8.
REQ-034 SHALL be checked by: rise and down together in LOW, plus down in IDLE -> no state change and no measurement.
REQ-035 SHALL be checked by: rst_n pulsed high during HIGH and with meas_valid=1 -> all outputs 0 immediately, and the first rise after release restarts from IDLE.

Source files
------------

// File: rtl/edge_meas_pkg.sv
// Shared types and defaults for the edge measurement block.
// Holds the FSM state encoding and the default counter width.
package edge_meas_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/edge_meas_sat_counter.sv
// Period counter: load-to-1, increment, saturates at all-ones with a sticky flag.
// One-cycle update latency; load has priority over increment and clears the flag.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (load_i) begin
      cnt_d = W'(1);
      sat_d = 1'b0;
    end else if (inc_i) begin
      // Flag only when an increment is actually refused at the ceiling.
      if (cnt_q == MAX) sat_d = 1'b1;
      else              cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/edge_meas.sv
// Measures high width and period between edge strobes; result appears one cycle after completion.
// One-entry output register: a completion while held and not accepted is dropped and flagged.
module edge_meas
  import edge_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise,
  input  logic             down,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             ovf,
  output logic             drop
);

  state_e           state_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  logic             valid_q, ovf_q, drop_q;
  logic [CNT_W-1:0] high_q, period_q;

  // Simultaneous rise and down cancel each other out.
  logic rise_ev, down_ev, complete, take;
  assign rise_ev  = rise & ~down;
  assign down_ev  = down & ~rise;
  assign complete = (state_q == LOW) & rise_ev;
  assign take     = complete & (~valid_q | meas_ready);

  sat_counter #(.W(CNT_W)) u_period (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (rise_ev),
    .inc_i  ((state_q != IDLE) & ~rise_ev),
    .cnt_o  (cnt),
    .sat_o  (sat)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      width_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (rise_ev) state_q <= HIGH;
        HIGH: begin
          if (down_ev) begin
            width_q <= cnt;
            state_q <= LOW;
          end
        end
        LOW:     if (rise_ev) state_q <= HIGH;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_q  <= 1'b0;
      high_q   <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= complete & valid_q & ~meas_ready;
      if (take) begin
        valid_q  <= 1'b1;
        high_q   <= width_q;
        period_q <= cnt;
        ovf_q    <= sat;
      end else if (meas_ready) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign meas_valid = valid_q;
  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign ovf        = ovf_q;
  assign drop       = drop_q;

endmodule

// File: tb/tb_edge_meas.sv
// Directed bench for edge_meas: scoreboard of expected measurements popped on handshake.
// A second instance with a 4-bit counter covers saturation.
module tb_edge_meas;

  logic        clk = 1'b0;
  logic        rst_n, rise, down, meas_ready;
  logic        meas_valid, ovf, drop;
  logic [15:0] high_cnt, period_cnt;

  logic        rise4, down4, ready4;
  logic        valid4, ovf4, drop4;
  logic [3:0]  high4, per4;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] per;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   drop_seen = 0;

  edge_meas #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rise       (rise),
    .down       (down),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .ovf        (ovf),
    .drop       (drop)
  );

  edge_meas #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rise       (rise4),
    .down       (down4),
    .meas_ready (ready4),
    .meas_valid (valid4),
    .high_cnt   (high4),
    .period_cnt (per4),
    .ovf        (ovf4),
    .drop       (drop4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] h,
                         input logic [15:0] p, input logic o);
    check({tag, "_valid"}, 32'(meas_valid), 32'(v));
    check({tag, "_high"}, 32'(high_cnt), 32'(h));
    check({tag, "_period"}, 32'(period_cnt), 32'(p));
    check({tag, "_ovf"}, 32'(ovf), 32'(o));
  endtask

  // Drive one cycle of strobes; returns 1ns after the next rising edge.
  task automatic cyc(input logic r, input logic d);
    rise = r;
    down = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every accepted measurement must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (drop) drop_seen++;
      if (meas_valid && meas_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_meas", 32'(period_cnt), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_high", 32'(high_cnt), 32'(e.hi));
          check("sb_period", 32'(period_cnt), 32'(e.per));
          check("sb_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rise = 1'b0; down = 1'b0; meas_ready = 1'b1;
    rise4 = 1'b0; down4 = 1'b0; ready4 = 1'b1;
    #2 rst_n = 1'b1;
    #1;
    chk_out("reset", 1'b0, 16'd0, 16'd0, 1'b0);
    check("reset_drop", 32'(drop), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;

    // Basic: rise@0, down@3, rise@10
    cyc(1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1);
    idle(6);
    check("basic_pre_valid", 32'(meas_valid), 32'd0);
    sb.push_back('{hi: 16'd3, per: 16'd10, ovf: 1'b0});
    cyc(1'b1, 1'b0);
    chk_out("basic", 1'b1, 16'd3, 16'd10, 1'b0);

    // Missing down: rise@0 (above), rise@4, down@6, rise@12
    cyc(1'b0, 1'b0);
    check("basic_cleared", 32'(meas_valid), 32'd0);
    idle(2);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    idle(5);
    check("restart_pre_valid", 32'(meas_valid), 32'd0);
    sb.push_back('{hi: 16'd2, per: 16'd8, ovf: 1'b0});
    cyc(1'b1, 1'b0);
    chk_out("restart", 1'b1, 16'd2, 16'd8, 1'b0);

    // Rise+down together in LOW is no event; counting continues
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    idle(3);
    check("both_no_meas", 32'(meas_valid), 32'd0);
    meas_ready = 1'b0;
    sb.push_back('{hi: 16'd1, per: 16'd6, ovf: 1'b0});
    cyc(1'b1, 1'b0);
    chk_out("both", 1'b1, 16'd1, 16'd6, 1'b0);

    // Held output: second completion is dropped
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0);
    chk_out("held", 1'b1, 16'd1, 16'd6, 1'b0);
    check("drop_pulse", 32'(drop), 32'd1);
    cyc(1'b0, 1'b0);
    chk_out("held2", 1'b1, 16'd1, 16'd6, 1'b0);
    check("drop_one_cycle", 32'(drop), 32'd0);

    // Asynchronous reset during HIGH with a held measurement
    rst_n = 1'b1;
    #1;
    chk_out("mid_reset", 1'b0, 16'd0, 16'd0, 1'b0);
    check("mid_reset_drop", 32'(drop), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    meas_ready = 1'b1;

    // IDLE ignores rise+down and down; first clean rise starts fresh
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    idle(2);
    check("idle_no_meas", 32'(meas_valid), 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    check("fresh_pre_valid", 32'(meas_valid), 32'd0);
    sb.push_back('{hi: 16'd2, per: 16'd4, ovf: 1'b0});
    cyc(1'b1, 1'b0);
    chk_out("fresh", 1'b1, 16'd2, 16'd4, 1'b0);
    idle(2);

    // 4-bit instance: rise@0, down@5, rise@40 saturates
    for (int c = 0; c <= 40; c++) begin
      rise4 = (c == 0 || c == 40);
      down4 = (c == 5);
      if (c == 40) check("w4_pre_valid", 32'(valid4), 32'd0);
      @(posedge clk);
      #1;
    end
    rise4 = 1'b0;
    down4 = 1'b0;
    check("w4_valid", 32'(valid4), 32'd1);
    check("w4_high", 32'(high4), 32'd5);
    check("w4_period", 32'(per4), 32'd15);
    check("w4_ovf", 32'(ovf4), 32'd1);
    check("w4_drop", 32'(drop4), 32'd0);
    idle(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("drop_count", 32'(drop_seen), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
